instr_loader: RTL and testbench
===============================

Name: instr_loader

Overview:
- Write-side counterpart to the instruction-fetch read path: fills instruction memory before or between program runs.
- Accepts a byte stream over a valid/ready handshake, assembles big-endian 32-bit instruction words, and issues one write per word to instruction memory.
- Write addresses are word-aligned byte addresses starting at BASE_ADDR and advancing by 4, matching the fetch stage's PC+4 sequencing.
- Raises done when the requested word count has been written.

Parameters:
- BASE_ADDR, 32'h00000000: byte address of the first written word; must be 4-aligned.
- MAX_WORDS, 256: capacity of instruction memory in words; the requested count saturates to this.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle request to begin a load; honoured only in IDLE or DONE.
- word_count  input  16  number of words to load; sampled on the cycle start is accepted.
- in_valid  input  1  source has a byte on in_data.
- in_data  input  8  stream byte.
- in_ready  output  1  loader accepts a byte this cycle.
- wr_en  output  1  instruction-memory write strobe, one cycle per word.
- wr_addr  output  32  byte address of the word being written.
- wr_data  output  32  assembled instruction word.
- busy  output  1  load in progress (COLLECT or WRITE).
- done  output  1  last load completed; held until next accepted start or reset.

Behaviour:
- Reset (rst=1 at an edge, from any state, including mid-word): state=IDLE, in_ready=0, wr_en=0, wr_addr=BASE_ADDR, wr_data=0, busy=0, done=0, byte counter=0, word counter=0. Any partially assembled word is discarded.
- States: IDLE, COLLECT, WRITE, DONE. busy=1 in COLLECT and WRITE. in_ready=1 only in COLLECT (combinational from state).
- IDLE/DONE with start=1:
  - Latch count = min(word_count, MAX_WORDS).
  - wr_addr<=BASE_ADDR, word counter<=0, byte counter<=0, done<=0.
  - Next state is COLLECT if count>0.
  - If count==0, next state is DONE with done=1 on the following cycle; no bytes are accepted and no writes occur.
- start is ignored while busy.
- COLLECT: a byte is accepted when in_valid && in_ready at an edge.
  - Big-endian placement: 1st byte -> wr_data[31:24], 2nd -> [23:16], 3rd -> [15:8], 4th -> [7:0].
  - The byte counter wraps 3->0.
  - Accepting the 4th byte moves to WRITE. in_valid=0 holds state with no change.
- WRITE: lasts exactly one cycle.
  - wr_en=1, with wr_addr and wr_data stable.
  - At the edge ending WRITE: wr_addr<=wr_addr+4 (32-bit, wraps modulo 2^32) and word counter increments.
  - If the new word count equals the latched count, go to DONE; otherwise return to COLLECT.
- Latency: 4th byte accepted at edge N -> wr_en high in cycle N+1. Minimum 5 cycles per word (4 accepts + 1 write).
- DONE: done=1, busy=0, in_ready=0, wr_en=0. wr_addr retains the last written address+4.
- wr_en is never asserted outside WRITE. wr_data is stable whenever wr_en=1.

Test Plan:
- Reset then idle: hold rst 2 cycles -> wr_en=0, in_ready=0, busy=0, done=0, wr_addr=0x00000000. Drive in_valid=1 with no start -> no bytes accepted.
- Single word: start with word_count=1, stream 0x20,0x08,0x00,0x05 back-to-back -> one wr_en pulse the cycle after the 4th accept with wr_addr=0x0, wr_data=0x20080005. done=1 next cycle.
- Three words with gaps: count=3, in_valid toggled 1/0 randomly -> writes at 0x0, 0x4, 0x8 in order with correct words; in_ready=0 during each WRITE cycle; done after the 3rd write.
- Zero and saturation: count=0 -> done within 2 cycles with no wr_en. MAX_WORDS=4 with count=10 -> exactly 4 writes, then done.
- Reset mid-word: after 2 bytes of word 2, assert rst -> all outputs return to reset values. A new start with count=1 writes the next 4 bytes at BASE_ADDR with no stale bytes.
- Start while busy plus restart: pulse start during COLLECT -> ignored, count unchanged. After done, start again -> done clears next cycle and addressing restarts at BASE_ADDR.

Source files
------------

// File: rtl/instr_loader.sv
// instr_loader: assembles big-endian 32-bit words from a byte stream and writes them
// to instruction memory at consecutive word addresses starting at BASE_ADDR.
module instr_loader #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int          MAX_WORDS = 256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [15:0] word_count,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic        in_ready,
   output logic        wr_en,
   output logic [31:0] wr_addr,
   output logic [31:0] wr_data,
   output logic        busy,
   output logic        done
);
   localparam logic [15:0] MAX = 16'(MAX_WORDS);
   typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;
   state_t      state, state_nx;
   logic [15:0] count, words, words_nx, sat_count;
   logic [1:0]  bytes;
   logic        accept, start_ok;
   assign in_ready  = state == COLLECT;
   assign wr_en     = state == WRITE;
   assign busy      = state == COLLECT || state == WRITE;
   assign done      = state == DONE;
   assign accept    = in_valid && in_ready;
   assign start_ok  = start && (state == IDLE || state == DONE);
   assign sat_count = word_count > MAX ? MAX : word_count;
   assign words_nx  = words + 16'd1;
   always_comb begin
      state_nx = state;
      case (state)
         IDLE, DONE: state_nx = start ? (sat_count == 16'd0 ? DONE : COLLECT) : state;
         COLLECT:    state_nx = accept && bytes == 2'd3 ? WRITE : COLLECT;
         WRITE:      state_nx = words_nx == count ? DONE : COLLECT;
         default:    state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end
   // Shifting each byte in from the bottom leaves the first byte in [31:24] after four accepts.
   always_ff @(posedge clk) begin
      if (rst) begin
         count   <= '0;
         words   <= '0;
         bytes   <= '0;
         wr_addr <= BASE_ADDR;
         wr_data <= '0;
      end else begin
         if (start_ok) begin
            count   <= sat_count;
            words   <= '0;
            bytes   <= '0;
            wr_addr <= BASE_ADDR;
         end
         if (accept) begin
            wr_data <= {wr_data[23:0], in_data};
            bytes   <= bytes + 2'd1;
         end
         if (state == WRITE) begin
            wr_addr <= wr_addr + 32'd4;
            words   <= words_nx;
         end
      end
   end
endmodule

// File: tb/tb_instr_loader.sv
// tb_instr_loader: scoreboard bench for instr_loader (default and MAX_WORDS=4 instances).
module tb_instr_loader;
   logic        clk = 0, rst = 1, start = 0, start4 = 0, in_valid = 0, sel = 0;
   logic [15:0] word_count = 0;
   logic [7:0]  in_data = 0;
   logic        in_ready, wr_en, busy, done, in_ready4, wr_en4, busy4, done4;
   logic [31:0] wr_addr, wr_data, wr_addr4, wr_data4;
   logic [63:0] sb[$];
   integer      checks = 0, errors = 0, writes = 0, w0;
   always #5 clk = ~clk;
   instr_loader dut (
      .clk(clk), .rst(rst), .start(start), .word_count(word_count), .in_valid(in_valid),
      .in_data(in_data), .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .busy(busy), .done(done)
   );
   instr_loader #(.MAX_WORDS(4)) dut4 (
      .clk(clk), .rst(rst), .start(start4), .word_count(word_count), .in_valid(in_valid),
      .in_data(in_data), .in_ready(in_ready4), .wr_en(wr_en4), .wr_addr(wr_addr4),
      .wr_data(wr_data4), .busy(busy4), .done(done4)
   );
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   always @(negedge clk) begin
      if (wr_en || wr_en4) begin
         logic [63:0] e;
         writes++;
         check("sb_nonempty", 32'(sb.size() > 0), 1);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check("wr_addr", sel ? wr_addr4 : wr_addr, e[63:32]);
            check("wr_data", sel ? wr_data4 : wr_data, e[31:0]);
         end
         check("ready_in_write", 32'(in_ready || in_ready4), 0);
      end
   end
   task automatic send_byte(input logic [7:0] b, input bit gaps);
      logic acc;
      acc = 0;
      in_valid = 0;
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      in_valid = 1;
      in_data  = b;
      for (int t = 0; t < 50 && !acc; t++) begin
         acc = sel ? in_ready4 : in_ready;
         @(posedge clk); #1;
      end
      if (!acc) check("accept_timeout", 0, 1);
      in_valid = 0;
   endtask
   task automatic send_word(input logic [31:0] a, input logic [31:0] d, input bit gaps);
      sb.push_back({a, d});
      for (int i = 3; i >= 0; i--) send_byte(d[8*i +: 8], gaps);
   endtask
   task automatic do_start(input logic which, input logic [15:0] n);
      word_count = n;
      if (which) start4 = 1; else start = 1;
      @(posedge clk); #1;
      start = 0; start4 = 0;
   endtask
   task automatic wait_done(input logic which);
      for (int t = 0; t < 40 && !(which ? done4 : done); t++) @(negedge clk);
      check("wait_done", 32'(which ? done4 : done), 1);
   endtask
   task automatic check_reset(input string tag);
      @(negedge clk);
      check({tag, "_wr_en"}, 32'(wr_en), 0);
      check({tag, "_in_ready"}, 32'(in_ready), 0);
      check({tag, "_busy"}, 32'(busy), 0);
      check({tag, "_done"}, 32'(done), 0);
      check({tag, "_wr_addr"}, wr_addr, 32'h0);
      check({tag, "_wr_data"}, wr_data, 32'h0);
   endtask
   initial begin
      repeat (2) @(posedge clk);
      check_reset("rst");
      @(posedge clk); #1 rst = 0;
      in_valid = 1;
      repeat (3) begin
         @(negedge clk);
         check("idle_no_ready", 32'(in_ready), 0);
         check("idle_not_busy", 32'(busy), 0);
      end
      @(posedge clk); #1 in_valid = 0;
      // single word, back-to-back bytes, exact write latency
      w0 = writes;
      do_start(0, 1);
      check("busy_after_start", 32'(busy), 1);
      send_word(32'h0, 32'h2008_0005, 0);
      @(negedge clk);
      check("wr_latency", 32'(wr_en), 1);
      @(negedge clk);
      check("done_after_1", 32'(done), 1);
      check("nwr_1", writes - w0, 1);
      // three words with random gaps
      w0 = writes;
      do_start(0, 3);
      @(negedge clk);
      check("done_cleared", 32'(done), 0);
      for (int i = 0; i < 3; i++) send_word(32'(4 * i), $urandom, 1);
      wait_done(0);
      check("nwr_3", writes - w0, 3);
      check("addr_after_3", wr_addr, 32'hC);
      // zero count from IDLE
      rst = 1; @(posedge clk); #1 rst = 0;
      w0 = writes;
      do_start(0, 0);
      @(negedge clk);
      check("zero_done", 32'(done), 1);
      check("zero_ready", 32'(in_ready), 0);
      check("nwr_0", writes - w0, 0);
      // saturation to MAX_WORDS=4
      sel = 1;
      w0 = writes;
      do_start(1, 10);
      for (int i = 0; i < 4; i++) send_word(32'(4 * i), $urandom, 1);
      wait_done(1);
      in_valid = 1;
      repeat (3) begin
         @(negedge clk);
         check("sat_no_ready", 32'(in_ready4), 0);
      end
      @(posedge clk); #1 in_valid = 0;
      check("nwr_sat", writes - w0, 4);
      sel = 0;
      // reset mid-word
      do_start(0, 3);
      send_word(32'h0, 32'h1122_3344, 0);
      send_byte(8'hEE, 0);
      send_byte(8'hFF, 0);
      rst = 1;
      @(posedge clk);
      check_reset("midrst");
      #1 rst = 0;
      do_start(0, 1);
      send_word(32'h0, 32'hA1B2_C3D4, 0);
      wait_done(0);
      check("addr_after_midrst", wr_addr, 32'h4);
      // start while busy is ignored
      do_start(0, 2);
      sb.push_back({32'h0, 32'hDEAD_BEEF});
      send_byte(8'hDE, 0);
      send_byte(8'hAD, 0);
      do_start(0, 1);
      check("busy_start_ign", 32'(busy), 1);
      send_byte(8'hBE, 0);
      send_byte(8'hEF, 0);
      repeat (2) @(negedge clk);
      check("not_done_1of2", 32'(done), 0);
      check("still_busy", 32'(busy), 1);
      send_word(32'h4, 32'h0BAD_F00D, 1);
      wait_done(0);
      // restart from DONE
      do_start(0, 1);
      @(negedge clk);
      check("restart_done_clr", 32'(done), 0);
      check("restart_addr", wr_addr, 32'h0);
      send_word(32'h0, 32'h1357_9BDF, 1);
      wait_done(0);
      check("sb_drained", 32'(sb.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
